muldiv_alu_sequencer: RTL and testbench
=======================================

Name: muldiv_alu_sequencer

Overview:
- Multi-cycle controller that executes RV32M multiply/divide instructions by sequencing the shared 32-bit ALU.
- Drives the ALU operation code and operands each cycle and reads back the ALU result.
- Sits beside the EX stage; holds the pipeline stalled from operation accept until the result is delivered.

Parameters:
- XLEN, 32, operand/result width; only 32 is supported.
- ITER_CNT_W, 6, width of the iteration counter; must hold the value XLEN.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- Start_i  input  1  request a new operation; sampled only in IDLE.
- Funct3_i  input  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- Rs1_i  input  32  multiplicand or dividend.
- Rs2_i  input  32  multiplier or divisor.
- Flush_i  input  1  abort the operation in flight.
- Busy_o  output  1  high in every state except IDLE.
- Stall_o  output  1  pipeline stall; equals Busy_o OR (Start_i in IDLE).
- Done_o  output  1  one-cycle pulse; Result_o is valid in this cycle.
- Result_o  output  32  final result; held until the next accepted Start_i.
- ALU_Operation_o  output  4  ALU op code: 0000 ADD, 0001 SUB.
- ALU_A_o  output  32  ALU operand A.
- ALU_B_o  output  32  ALU operand B.
- ALU_Result_i  input  32  combinational ALU result; used in the same cycle.

Behaviour:
- Reset: state IDLE; all registers cleared; every output is 0 (ALU_Operation_o = ADD, operands 0).
- Start_i is accepted only in IDLE. Funct3_i, Rs1_i and Rs2_i are captured on that edge. A Start_i seen in any other state is ignored.
- States: IDLE -> PREP -> ITER (XLEN cycles) -> FIX -> DONE -> IDLE.
- Nominal latency: Done_o is asserted 35 cycles after the accepting edge. The operation is accepted at edge 0, PREP runs at 1, ITER at 2..33, FIX at 34, DONE at 35.
- PREP, signedness:
  - Signed operands are converted to their absolute values. Rs1 is signed for MUL, MULH, MULHSU, DIV and REM. Rs2 is signed for MUL, MULH, DIV and REM.
  - The negation is done locally, not in the ALU.
  - Result sign is recorded as follows. For MUL, MULH and MULHSU: sign(Rs1) XOR sign(Rs2, when signed). For DIV the quotient sign is sign(Rs1) XOR sign(Rs2). For REM the remainder takes the sign of the dividend.
- PREP, special division cases (these jump PREP -> DONE; Done_o is asserted 2 cycles after accept):
  - Divide by zero: quotient is 0xFFFFFFFF; remainder is Rs1.
  - Signed overflow (0x80000000 / 0xFFFFFFFF): quotient is 0x80000000; remainder is 0.
- ITER, multiply (shift-add):
  - ALU_Operation_o = ADD, ALU_A_o = acc_hi, ALU_B_o = multiplicand if multiplier bit 0 is 1, else 0.
  - carry = (ALU_Result_i <u ALU_A_o).
  - {acc_hi, acc_lo} <= {carry, ALU_Result_i, acc_lo} >> 1. acc_lo is preloaded with the multiplier.
- ITER, divide (restoring):
  - {msb, rem_sh} = {rem, dividend msb} shifted left by 1.
  - ALU_Operation_o = SUB, ALU_A_o = rem_sh, ALU_B_o = divisor.
  - take = msb OR (rem_sh >=u divisor).
  - If take is 1, rem <= ALU_Result_i; otherwise rem <= rem_sh.
  - The quotient bit shifted in equals take.
- Outside ITER, ALU_Operation_o = ADD with both operands 0.
- Iteration counter: counts XLEN-1 down to 0; ITER -> FIX when it reaches 0.
- FIX:
  - Apply two's-complement negation per the recorded sign. Multiply negates the 64-bit product; divide negates the quotient or remainder.
  - Select the result: the low 32 bits for MUL, the high 32 bits for MULH, MULHSU and MULHU, the quotient for DIV/DIVU, the remainder for REM/REMU.
- DONE: Result_o is registered and Done_o is 1 for exactly one cycle. The next state is IDLE. A new Start_i is accepted the cycle after DONE.
- Flush_i:
  - In any non-IDLE state, the next state is IDLE and no Done_o is produced.
  - Result_o keeps its previous value.
  - Flush_i has priority over the FSM advance, including in DONE. If Flush_i is high in DONE, Done_o is still asserted in that cycle, because the pulse is combinational from the state.
- Reset during an operation: return to IDLE on the next edge; all outputs go to their reset values.

Decomposition:
- Shared package riscv_pkg holds:
  - The ALU op-code constants (ADD = 4'b0000, SUB = 4'b0001, and the rest).
  - The Funct3 M-extension constants.
  - The FSM state encoding (IDLE, PREP, ITER, FIX, DONE).
- Single module, no sub-module. The sign pre/post negation may be a local function.

Test Plan:
- MUL 7 x 6 -> Done_o 35 cycles after Start_i; Result_o = 42; Busy_o and Stall_o high throughout.
- MULH 0xFFFFFFFF (-1) x 2 -> Result_o = 0xFFFFFFFF. MULHU with the same operands -> 0x00000001. MUL with the same operands -> 0xFFFFFFFE.
- DIV -7 / 2 -> 0xFFFFFFFD (-3). REM -7 / 2 -> 0xFFFFFFFF (-1). DIVU 0xFFFFFFFF / 0x80000000 -> 1.
- DIVU 5 / 0 -> 0xFFFFFFFF with Done_o 2 cycles after accept. REM 5 / 0 -> 5. DIV 0x80000000 / -1 -> 0x80000000.
- Flush_i asserted at cycle 10 of a MUL -> IDLE next cycle, no Done_o, Result_o unchanged. A Start_i held during Busy_o is ignored.
- Reset pulsed mid-DIV -> all outputs 0 on the next cycle. A following MUL 3 x 3 returns 9.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV32 definitions: ALU op codes, M-extension funct3 values and
// the multiply/divide sequencer state encoding.
package riscv_pkg;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLL  = 4'b0101;
  localparam logic [3:0] ALU_SRL  = 4'b0110;
  localparam logic [3:0] ALU_SRA  = 4'b0111;
  localparam logic [3:0] ALU_SLT  = 4'b1000;
  localparam logic [3:0] ALU_SLTU = 4'b1001;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PREP = 3'd1,
    ST_ITER = 3'd2,
    ST_FIX  = 3'd3,
    ST_DONE = 3'd4
  } md_state_e;

endpackage

// File: rtl/muldiv_alu_sequencer.sv
// RV32M multiply/divide sequencer: shift-add multiply and restoring divide,
// one bit per cycle, using the shared pipeline ALU for the add/subtract.
module muldiv_alu_sequencer
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned ITER_CNT_W = 6
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            Start_i,
  input  logic [2:0]      Funct3_i,
  input  logic [XLEN-1:0] Rs1_i,
  input  logic [XLEN-1:0] Rs2_i,
  input  logic            Flush_i,
  output logic            Busy_o,
  output logic            Stall_o,
  output logic            Done_o,
  output logic [XLEN-1:0] Result_o,
  output logic [3:0]      ALU_Operation_o,
  output logic [XLEN-1:0] ALU_A_o,
  output logic [XLEN-1:0] ALU_B_o,
  input  logic [XLEN-1:0] ALU_Result_i
);

  localparam int unsigned PW = 2 * XLEN;

  md_state_e             state_q, state_d;
  logic [2:0]            funct3_q;
  logic                  neg_q;
  logic [ITER_CNT_W-1:0] cnt_q;
  logic [XLEN-1:0]       acc_hi_q, acc_lo_q, opb_q, result_q;

  function automatic logic [XLEN-1:0] neg_xlen(input logic [XLEN-1:0] x);
    return ~x + XLEN'(1);
  endfunction

  function automatic logic [PW-1:0] neg_wide(input logic [PW-1:0] x);
    return ~x + PW'(1);
  endfunction

  // Operation decode; in PREP acc_lo_q holds raw Rs1 and opb_q raw Rs2
  logic            is_div, rs1_signed, rs2_signed, s1, s2, sign_res;
  logic            div_zero, div_ovf, special;
  logic [XLEN-1:0] abs1, abs2, special_result;

  assign is_div     = funct3_q[2];
  assign rs1_signed = is_div ? ~funct3_q[0] : (funct3_q != F3_MULHU);
  assign rs2_signed = is_div ? ~funct3_q[0] : ~funct3_q[1];
  assign s1         = rs1_signed & acc_lo_q[XLEN-1];
  assign s2         = rs2_signed & opb_q[XLEN-1];
  assign sign_res   = (is_div && funct3_q[1]) ? s1 : (s1 ^ s2);
  assign abs1       = s1 ? neg_xlen(acc_lo_q) : acc_lo_q;
  assign abs2       = s2 ? neg_xlen(opb_q) : opb_q;

  assign div_zero = is_div && (opb_q == '0);
  assign div_ovf  = is_div && !funct3_q[0] && (acc_lo_q == {1'b1, {(XLEN-1){1'b0}}})
                    && (opb_q == '1);
  assign special  = div_zero || div_ovf;
  assign special_result = div_zero ? (funct3_q[1] ? acc_lo_q : '1)
                                   : (funct3_q[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}});

  // Per-iteration datapath terms
  logic [XLEN-1:0] mul_b, rem_sh;
  logic            carry, take;

  assign mul_b  = acc_lo_q[0] ? opb_q : '0;
  assign carry  = ALU_Result_i < acc_hi_q;
  assign rem_sh = {acc_hi_q[XLEN-2:0], acc_lo_q[XLEN-1]};
  assign take   = acc_hi_q[XLEN-1] | (rem_sh >= opb_q);

  // Post-correction and result selection
  logic [PW-1:0]   prod_fix;
  logic [XLEN-1:0] div_sel, div_fix, fix_result;

  assign prod_fix   = neg_q ? neg_wide({acc_hi_q, acc_lo_q}) : {acc_hi_q, acc_lo_q};
  assign div_sel    = funct3_q[1] ? acc_hi_q : acc_lo_q;
  assign div_fix    = neg_q ? neg_xlen(div_sel) : div_sel;
  assign fix_result = is_div ? div_fix
                    : ((funct3_q == F3_MUL) ? prod_fix[XLEN-1:0] : prod_fix[PW-1:XLEN]);

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d         = state_q;
    Busy_o          = 1'b1;
    Done_o          = 1'b0;
    ALU_Operation_o = ALU_ADD;
    ALU_A_o         = '0;
    ALU_B_o         = '0;
    case (state_q)
      ST_IDLE: begin
        Busy_o = 1'b0;
        if (Start_i) state_d = ST_PREP;
      end
      ST_PREP: state_d = special ? ST_DONE : ST_ITER;
      ST_ITER: begin
        if (is_div) begin
          ALU_Operation_o = ALU_SUB;
          ALU_A_o         = rem_sh;
          ALU_B_o         = opb_q;
        end else begin
          ALU_A_o = acc_hi_q;
          ALU_B_o = mul_b;
        end
        if (cnt_q == '0) state_d = ST_FIX;
      end
      ST_FIX:  state_d = ST_DONE;
      ST_DONE: begin
        Done_o  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (Flush_i && (state_q != ST_IDLE)) state_d = ST_IDLE;
    Stall_o = Busy_o | ((state_q == ST_IDLE) & Start_i);
  end

  // Datapath registers; only the architectural result is protected from flush
  always_ff @(posedge clk) begin
    if (reset) begin
      funct3_q <= '0;
      neg_q    <= 1'b0;
      cnt_q    <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      opb_q    <= '0;
      result_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (Start_i) begin
            funct3_q <= Funct3_i;
            acc_lo_q <= Rs1_i;
            opb_q    <= Rs2_i;
            acc_hi_q <= '0;
          end
        end
        ST_PREP: begin
          neg_q    <= sign_res;
          cnt_q    <= ITER_CNT_W'(XLEN - 1);
          acc_hi_q <= '0;
          if (special) begin
            if (!Flush_i) result_q <= special_result;
          end else if (is_div) begin
            acc_lo_q <= abs1;
            opb_q    <= abs2;
          end else begin
            acc_lo_q <= abs2;
            opb_q    <= abs1;
          end
        end
        ST_ITER: begin
          cnt_q <= cnt_q - ITER_CNT_W'(1);
          if (is_div) begin
            acc_hi_q <= take ? ALU_Result_i : rem_sh;
            acc_lo_q <= {acc_lo_q[XLEN-2:0], take};
          end else begin
            acc_hi_q <= {carry, ALU_Result_i[XLEN-1:1]};
            acc_lo_q <= {ALU_Result_i[0], acc_lo_q[XLEN-1:1]};
          end
        end
        ST_FIX: begin
          if (!Flush_i) result_q <= fix_result;
        end
        default: ;
      endcase
    end
  end

  assign Result_o = result_q;

endmodule

// File: tb/tb_muldiv_alu_sequencer.sv
// Directed bench for muldiv_alu_sequencer with a behavioural ADD/SUB ALU.
module tb_muldiv_alu_sequencer;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] rs1, rs2;
  logic        flush;
  logic        busy, stall, done;
  logic [31:0] result;
  logic [3:0]  alu_op;
  logic [31:0] alu_a, alu_b, alu_res;

  int n_vec = 0;
  int n_err = 0;

  muldiv_alu_sequencer dut (
    .clk             (clk),
    .reset           (reset),
    .Start_i         (start),
    .Funct3_i        (funct3),
    .Rs1_i           (rs1),
    .Rs2_i           (rs2),
    .Flush_i         (flush),
    .Busy_o          (busy),
    .Stall_o         (stall),
    .Done_o          (done),
    .Result_o        (result),
    .ALU_Operation_o (alu_op),
    .ALU_A_o         (alu_a),
    .ALU_B_o         (alu_b),
    .ALU_Result_i    (alu_res)
  );

  assign alu_res = (alu_op == 4'b0001) ? (alu_a - alu_b) : (alu_a + alu_b);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Issue one operation and track it to Done_o; latency counted in cycles after accept
  task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int exp_lat,
                        input bit hold);
    int cyc;
    bit busy_ok;
    bit got;
    @(negedge clk);
    start = 1'b1; funct3 = f3; rs1 = a; rs2 = b;
    #1;
    check({tag, "/stall_req"}, 32'(stall), 32'd1);
    cyc = 0; busy_ok = 1'b1; got = 1'b0;
    while (cyc < 60 && !got) begin
      @(negedge clk);
      cyc++;
      if (hold && cyc < 20) begin
        funct3 = 3'b100; rs1 = 32'h0000_1234; rs2 = 32'h0000_0003;
      end else begin
        start = 1'b0;
      end
      if (!busy || !stall) busy_ok = 1'b0;
      if (done) got = 1'b1;
    end
    start = 1'b0;
    check({tag, "/latency"}, 32'(cyc), 32'(exp_lat));
    check({tag, "/result"}, result, exp);
    check({tag, "/busy_held"}, 32'(busy_ok), 32'd1);
    @(negedge clk);
    check({tag, "/done_1cyc"}, 32'(done), 32'd0);
    check({tag, "/idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int cyc;
    int n_done;
    reset = 1'b1; start = 1'b0; funct3 = '0; rs1 = '0; rs2 = '0; flush = 1'b0;
    repeat (3) @(negedge clk);
    check("rst/busy", 32'(busy), 32'd0);
    check("rst/stall", 32'(stall), 32'd0);
    check("rst/done", 32'(done), 32'd0);
    check("rst/result", result, 32'd0);
    check("rst/alu_op", 32'(alu_op), 32'd0);
    check("rst/alu_a", alu_a, 32'd0);
    check("rst/alu_b", alu_b, 32'd0);
    reset = 1'b0;

    run_op("mul7x6",     3'b000, 32'd7,         32'd6,         32'd42,        35, 1'b0);
    run_op("mulh_m1x2",  3'b001, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, 35, 1'b0);
    run_op("mulhu_m1x2", 3'b011, 32'hFFFF_FFFF, 32'd2,         32'h0000_0001, 35, 1'b0);
    run_op("mul_m1x2",   3'b000, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFE, 35, 1'b0);
    run_op("mulhsu",     3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 35, 1'b0);
    run_op("div_m7_2",   3'b100, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 35, 1'b0);
    run_op("rem_m7_2",   3'b110, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 35, 1'b0);
    run_op("divu_big",   3'b101, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0001, 35, 1'b0);
    run_op("remu_100_7", 3'b111, 32'd100,       32'd7,         32'd2,         35, 1'b0);
    run_op("divu_5_0",   3'b101, 32'd5,         32'd0,         32'hFFFF_FFFF, 2,  1'b0);
    run_op("rem_5_0",    3'b110, 32'd5,         32'd0,         32'd5,         2,  1'b0);
    run_op("div_ovf",    3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 2,  1'b0);
    run_op("mul_hold",   3'b000, 32'd7,         32'd6,         32'd42,        35, 1'b1);

    // Flush a MUL in flight; previous result must survive
    @(negedge clk);
    start = 1'b1; funct3 = 3'b000; rs1 = 32'd5; rs2 = 32'd5;
    cyc = 0;
    @(negedge clk); cyc++; start = 1'b0;
    while (cyc < 10) begin @(negedge clk); cyc++; end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush/busy", 32'(busy), 32'd0);
    n_done = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) n_done++;
    end
    check("flush/no_done", 32'(n_done), 32'd0);
    check("flush/result", result, 32'd42);

    // Reset in the middle of a DIV
    @(negedge clk);
    start = 1'b1; funct3 = 3'b100; rs1 = 32'd100; rs2 = 32'd7;
    cyc = 0;
    @(negedge clk); cyc++; start = 1'b0;
    while (cyc < 15) begin @(negedge clk); cyc++; end
    check("middiv/busy", 32'(busy), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    check("midrst/busy", 32'(busy), 32'd0);
    check("midrst/stall", 32'(stall), 32'd0);
    check("midrst/done", 32'(done), 32'd0);
    check("midrst/result", result, 32'd0);
    check("midrst/alu_op", 32'(alu_op), 32'd0);
    check("midrst/alu_a", alu_a, 32'd0);
    check("midrst/alu_b", alu_b, 32'd0);
    reset = 1'b0;
    run_op("mul3x3", 3'b000, 32'd3, 32'd3, 32'd9, 35, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "simulation timeout");
  end

endmodule
